adder_4: RTL and testbench
==========================

Name: adder_4

Overview:
- 4-bit binary adder with carry-in and carry-out, built as a ripple chain of four 1-bit full adders.
- Combinational sum/carry outputs serve datapath consumers directly.
- A registered copy with a load enable serves timing-critical consumers.
- Sits as a leaf arithmetic cell used by wider adders and ALU slices.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all registers update on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- a  input  4  operand A, unsigned (two's-complement when overflow feature used)
- b  input  4  operand B
- cin  input  1  carry-in
- en  input  1  load enable for the registered outputs
- s  output  4  combinational sum, (a+b+cin)[3:0]
- cout  output  1  combinational carry-out, (a+b+cin)[4]
- p  output  4  per-bit propagate, a^b
- g  output  4  per-bit generate, a&b
- s_q  output  4  registered sum
- cout_q  output  1  registered carry-out
- ovf  output  1  combinational signed overflow (see Optional Feature)
- ovf_q  output  1  registered signed overflow

Behaviour:
- Combinational path, no clock dependence:
  - c0=cin; bit i: s[i]=a[i]^b[i]^c_i, c_(i+1)=(a[i]&b[i])|(c_i&(a[i]^b[i])); cout=c4.
  - {cout,s} must equal the 5-bit sum a+b+cin for all 512 input combinations.
  - s, cout, p, g settle within the same delta/propagation time as any input change; no latches.
- Outputs must be fully 2-state (never X/Z) whenever a, b and cin are 2-state.
- Registered path, on rising clk:
  - rst_n=0: s_q=0, cout_q=0, ovf_q=0, regardless of en (reset has priority).
  - rst_n=1, en=1: s_q<=s, cout_q<=cout, ovf_q<=ovf.
  - rst_n=1, en=0: hold previous values.
- Latency: s/cout 0 cycles; s_q/cout_q 1 cycle after the enabled edge.
- Reset asserted mid-stream: registered outputs clear on that edge. Combinational outputs are unaffected by reset.
- Wrap-around: a=15, b=15, cin=1 gives s=15, cout=1. a=15, b=0, cin=1 gives s=0, cout=1.
- Power-up before first reset: registered outputs undefined. The bench must apply reset first.

Optional Feature:
- Macro: ADDER4_OVERFLOW_EN.
- Defined:
  - ovf = (a[3]==b[3]) & (s[3]!=a[3]), equivalently c3^c4.
  - ovf_q registers ovf under the same en/reset rules as s_q.
- Not defined:
  - ovf and ovf_q are tied to constant 0 and no overflow logic is synthesized.
  - Port list is identical in both builds.

Test Plan:
- Exhaustive combinational sweep:
  - Drive i=0..511 with a=i[3:0], b=i[7:4], cin=i[8], waiting 1 ns each.
  - Check {cout,s} === a+b+cin, p===a^b, g===a&b, using 4-state compares; zero errors required.
- Boundary cases:
  - a=4'hF, b=4'h1, cin=0 -> s=0, cout=1.
  - a=0, b=0, cin=1 -> s=1, cout=0.
  - a=4'hF, b=4'hF, cin=1 -> s=4'hF, cout=1.
- Reset:
  - Hold rst_n=0 one edge with en=1 and a=5, b=6 -> s_q=0, cout_q=0, while s=4'hB combinationally.
  - Release rst_n -> next edge gives s_q=4'hB, cout_q=0.
- Enable hold:
  - Load a=9, b=9, cin=0 (s_q=2, cout_q=1).
  - Set en=0 and change to a=1, b=1 -> s_q stays 2 and cout_q stays 1 for 3 edges, while s=2 combinationally.
- Overflow (with ADDER4_OVERFLOW_EN):
  - a=4'h7, b=4'h1, cin=0 -> ovf=1.
  - a=4'h8, b=4'h8 -> ovf=1, cout=1.
  - a=4'h7, b=4'h8 -> ovf=0.
  - Without the macro, ovf=0 for all three cases.
- Reset mid-operation:
  - en=1 with streaming inputs; assert rst_n=0 on one edge -> registered outputs 0 that edge.
  - On the next edge with rst_n=1 -> they resume tracking s/cout.

Source files
------------

// File: rtl/adder_4_if.sv
// adder_4_if: operand, enable and result bundle for the adder_4 leaf cell.
//   master: drives a, b, cin, en; observes all results.
//   slave : the adder itself; consumes operands, drives results.
//   a, b    : 4-bit operands
//   cin     : carry-in
//   en      : load enable for the registered results
//   s/cout  : combinational sum and carry-out
//   p/g     : per-bit propagate (a^b) and generate (a&b)
//   s_q/cout_q/ovf_q : registered copies
//   ovf     : combinational signed overflow (zero unless ADDER4_OVERFLOW_EN)
interface adder_4_if;
  localparam int unsigned WIDTH = 4;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             en;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf;
  logic             ovf_q;

  modport master (
    output a, b, cin, en,
    input  s, cout, p, g, s_q, cout_q, ovf, ovf_q
  );

  modport slave (
    input  a, b, cin, en,
    output s, cout, p, g, s_q, cout_q, ovf, ovf_q
  );
endinterface

// File: rtl/adder_4.sv
// adder_4: 4-bit ripple-carry adder leaf cell with a registered result copy.
//   clk   : rising-edge clock for the registered outputs
//   rst_n : synchronous active-low reset; clears s_q/cout_q/ovf_q, beats en
//   bus   : adder_4_if.slave carrying operands, enable and all results
// Combinational s/cout/p/g are valid in the same cycle as the operands;
// s_q/cout_q/ovf_q follow one edge after an enabled edge.
// Optional macro ADDER4_OVERFLOW_EN adds signed overflow detection; without it
// ovf and ovf_q are constant zero and no overflow logic exists.
module adder_4 (
  input  logic       clk,
  input  logic       rst_n,
  adder_4_if.slave   bus
);
  localparam int unsigned WIDTH = 4;

  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             ovf_c;

  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  // Ripple chain of full adders; carry[i] is the carry into bit i.
  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign prop[i]    = bus.a[i] ^ bus.b[i];
    assign gen[i]     = bus.a[i] & bus.b[i];
    assign sum[i]     = prop[i] ^ carry[i];
    assign carry[i+1] = gen[i] | (carry[i] & prop[i]);
  end

  assign bus.s    = sum;
  assign bus.cout = carry[WIDTH];
  assign bus.p    = prop;
  assign bus.g    = gen;

  // Registered copy of sum/carry for timing-critical consumers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (bus.en) begin
      sum_q   <= sum;
      carry_q <= carry[WIDTH];
    end
  end

  assign bus.s_q    = sum_q;
  assign bus.cout_q = carry_q;

`ifdef ADDER4_OVERFLOW_EN
  logic ovf_r;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_c = carry[WIDTH-1] ^ carry[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (bus.en) begin
      ovf_r <= ovf_c;
    end
  end

  assign bus.ovf_q = ovf_r;
`else
  assign ovf_c     = 1'b0;
  assign bus.ovf_q = 1'b0;
`endif

  assign bus.ovf = ovf_c;
endmodule

// File: tb/tb_adder_4.sv
// tb_adder_4: self-checking bench for adder_4 (exhaustive sweep, vector
// table, reset/enable sequences and randomized streaming against a model).
module tb_adder_4;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  adder_4_if bus ();

  adder_4 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_s;
    logic       exp_cout;
    logic       exp_ovf;   // expected when overflow detection is built in
  } vec_t;

  vec_t vecs [6];

  // Model of the registered outputs.
  logic [3:0] m_sq;
  logic       m_cq;
  logic       m_oq;

  function automatic logic ovf_ref(input logic [3:0] a, input logic [3:0] b,
                                   input logic cin);
`ifdef ADDER4_OVERFLOW_EN
    int sum;
    sum = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (sum > 7) || (sum < -8);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic en);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    bus.en  = en;
  endtask

  // Advance one rising edge, update the model from the pre-edge inputs,
  // then compare the registered outputs.
  task automatic step(input string name);
    int tot;
    tot = int'(bus.a) + int'(bus.b) + int'(bus.cin);
    if (!rst_n) begin
      m_sq = 4'h0;
      m_cq = 1'b0;
      m_oq = 1'b0;
    end else if (bus.en) begin
      m_sq = 4'(tot);
      m_cq = (tot > 15);
      m_oq = ovf_ref(bus.a, bus.b, bus.cin);
    end
    @(posedge clk);
    #1;
    chk({name, ".s_q"},    8'(bus.s_q),    8'(m_sq));
    chk({name, ".cout_q"}, 8'(bus.cout_q), 8'(m_cq));
    chk({name, ".ovf_q"},  8'(bus.ovf_q),  8'(m_oq));
  endtask

  task automatic chk_comb(input string name);
    int tot;
    tot = int'(bus.a) + int'(bus.b) + int'(bus.cin);
    chk({name, ".sum"}, 8'({bus.cout, bus.s}), 8'(tot));
    chk({name, ".p"},   8'(bus.p),   8'(bus.a ^ bus.b));
    chk({name, ".g"},   8'(bus.g),   8'(bus.a & bus.b));
    chk({name, ".ovf"}, 8'(bus.ovf), 8'(ovf_ref(bus.a, bus.b, bus.cin)));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_sq = 4'h0;
    m_cq = 1'b0;
    m_oq = 1'b0;

    vecs[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[1] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
    vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    vecs[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
    vecs[5] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b0};

    // Reset first: registered outputs are undefined before it.
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    #2;
    step("por");

    // Exhaustive combinational sweep.
    for (int i = 0; i < 512; i++) begin
      bus.a   = 4'(i);
      bus.b   = 4'(i >> 4);
      bus.cin = 1'((i >> 8) & 1);
      #1;
      chk_comb("sweep");
    end

    // Boundary and overflow vectors.
    for (int k = 0; k < 6; k++) begin
      drive(vecs[k].a, vecs[k].b, vecs[k].cin, 1'b0);
      #1;
      chk("vec.s",    8'(bus.s),    8'(vecs[k].exp_s));
      chk("vec.cout", 8'(bus.cout), 8'(vecs[k].exp_cout));
`ifdef ADDER4_OVERFLOW_EN
      chk("vec.ovf",  8'(bus.ovf),  8'(vecs[k].exp_ovf));
`else
      chk("vec.ovf",  8'(bus.ovf),  8'h00);
`endif
    end

    // Reset beats enable; combinational path ignores reset.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(4'h5, 4'h6, 1'b0, 1'b1);
    #1;
    chk("rst.s_comb", 8'(bus.s), 8'h0B);
    step("rst.hold");
    chk("rst.s_q_zero", 8'(bus.s_q), 8'h00);
    rst_n = 1'b1;
    step("rst.release");
    chk("rst.s_q_B", 8'(bus.s_q), 8'h0B);

    // Enable hold.
    drive(4'h9, 4'h9, 1'b0, 1'b1);
    step("hold.load");
    chk("hold.load_s_q", 8'({bus.cout_q, bus.s_q}), 8'h12);
    drive(4'h1, 4'h1, 1'b0, 1'b0);
    #1;
    chk("hold.s_comb", 8'(bus.s), 8'h02);
    for (int k = 0; k < 3; k++) begin
      step("hold.edge");
      chk("hold.s_q_kept", 8'({bus.cout_q, bus.s_q}), 8'h12);
    end

    // Streaming with a single mid-stream reset edge.
    for (int k = 0; k < 8; k++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      rst_n = (k != 4);
      step("stream");
      if (k == 4) chk("stream.rst_zero", 8'({bus.cout_q, bus.s_q}), 8'h00);
    end
    rst_n = 1'b1;

    // Randomized operation with occasional reset and enable toggling.
    for (int k = 0; k < 300; k++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      rst_n = ($urandom_range(0, 19) != 0);
      #1;
      chk_comb("rand");
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
